candidate_selector: RTL and testbench
=====================================

Name: candidate_selector

Overview:
- Consumer/reader of the hash table's query result vector `count_bus`.
- After a query, software or the top FSM pulses `start`. The block then scans the per-window hit counts serially.
- Every window whose count is at or above a programmable threshold is streamed out over a valid/ready interface.
- It also reports the single best-matching window and the number of candidates. It sits between the hash table and the downstream alignment/reporting stage.

Parameters:
- MAX_WINDOWS_IN_REFERENCE, 1024, number of entries on `count_bus`.
- LOG2_MAX_WINDOWS, 10, scan index width.
- COUNT_WIDTH, 32, width of each `count_bus` entry and of the count outputs.

Ports:
- clk  input  1  single clock, rising edge.
- reset_candidate_selector_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; starts a scan; ignored while `busy`=1.
- num_windows  input  32  number of windows to scan; sampled on `start`.
- threshold  input  COUNT_WIDTH  minimum count for a candidate; sampled on `start`.
- count_bus  input  COUNT_WIDTH x MAX_WINDOWS_IN_REFERENCE  per-window hit counts; must stay stable from `start` until `done`.
- cand_valid  output  1  candidate present on `cand_window_id`/`cand_count`.
- cand_ready  input  1  downstream accepts the candidate; transfer occurs when `cand_valid` and `cand_ready` are both 1.
- cand_window_id  output  32  window index of the candidate.
- cand_count  output  COUNT_WIDTH  count of the candidate.
- busy  output  1  high from the cycle after `start` until `done` is pulsed.
- done  output  1  one-cycle pulse when the scan is complete and the last candidate has been accepted.
- best_window_id  output  32  window with the highest count.
- best_count  output  COUNT_WIDTH  that highest count.
- num_candidates  output  32  number of candidates emitted in the last scan.

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; scan index 0.
- FSM states: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On `start`, latch `threshold` and the scan limit `lim` = min(`num_windows`, MAX_WINDOWS_IN_REFERENCE).
  - Clear `best_*` and `num_candidates`, set index to 0, go to SCAN.
  - If `lim`=0, go directly to DRAIN.
- SCAN:
  - Index `idx` advances only when the output register is free, i.e. `!cand_valid || cand_ready`.
  - When advancing, evaluate `count_bus[idx]`. If count >= threshold, the next-cycle outputs are `cand_valid`=1, `cand_window_id`=`idx`, `cand_count`=count, and `num_candidates` increments.
  - When advancing with no hit, `cand_valid` clears if the previous candidate was accepted.
  - When stalled (`cand_valid` && !`cand_ready`), the candidate outputs hold stable and `idx` holds.
  - Best tracking happens on every evaluated index regardless of threshold. Update only when count > `best_count` (strict), so ties keep the lowest window id. An all-zero bus gives best = (0, 0).
  - After evaluating `idx` = `lim`-1, go to DRAIN.
- DRAIN: go to DONE once `cand_valid`=0 or the pending candidate transfers this cycle; `cand_valid` is 0 on entry to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `busy` drops in the same cycle that `done` is asserted.
- Latency:
  - A hit at index 0 appears on the output 2 cycles after `start`.
  - With `cand_ready` held at 1, throughput is 1 window per cycle.
  - Full scan of N windows: `done` at `start`+N+2.
- Results persistence: `best_*` and `num_candidates` remain stable after `done` until the next accepted `start`.
- Threshold 0: every scanned window is a candidate.
- `start` during SCAN/DRAIN/DONE: ignored.
- Reset mid-scan: everything returns to reset values immediately; any pending candidate is dropped.

Decomposition:
- Package `lsh_pkg`: COUNT_WIDTH, MAX_WINDOWS_IN_REFERENCE, LOG2_MAX_WINDOWS, and the state enum type `sel_state_t` (IDLE, SCAN, DRAIN, DONE), shared with hash_table and the top-level controller.
- No sub-module. The single module contains the FSM, index counter, output register, and best/count trackers.

Test Plan:
- `num_windows`=4, counts {3,0,5,5}, `threshold`=3, `cand_ready`=1 -> candidates (0,3),(2,5),(3,5); best=(2,5); `num_candidates`=3; `done` at `start`+6.
- Same stimulus with `cand_ready` low for 3 cycles while (2,5) is presented -> (2,5) holds for 4 cycles, no drops or duplicates; `done` is delayed by 3 cycles.
- `num_windows`=0 -> no `cand_valid`; `done` at `start`+2; best=(0,0); `num_candidates`=0.
- `num_windows`=2000, all counts 1, `threshold`=1 -> 1024 candidates with ids 0..1023; best=(0,1); `num_candidates`=1024.
- `start` pulsed mid-scan -> ignored and the scan completes unchanged; then assert reset at scan index 10 -> all outputs 0 immediately; a fresh `start` afterwards produces correct results.
- `threshold`=0, counts {0,2,2} -> 3 candidates; best=(1,2), showing the tie resolves to the lowest id.

Source files
------------

// File: rtl/lsh_pkg.sv
// Shared LSH parameters and the candidate selector state encoding.
package lsh_pkg;

  localparam int unsigned COUNT_WIDTH              = 32;
  localparam int unsigned MAX_WINDOWS_IN_REFERENCE = 1024;
  localparam int unsigned LOG2_MAX_WINDOWS         = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sel_state_t;

endpackage

// File: rtl/candidate_selector.sv
// Serially scans the hash-table hit counts, streams windows at or above threshold
// over valid/ready, and tracks the best window and the candidate count.
module candidate_selector
  import lsh_pkg::*;
(
  input  logic                                            clk,
  input  logic                                            reset_candidate_selector_n,
  input  logic                                            start,
  input  logic [31:0]                                     num_windows,
  input  logic [COUNT_WIDTH-1:0]                          threshold,
  input  logic [COUNT_WIDTH*MAX_WINDOWS_IN_REFERENCE-1:0] count_bus,
  output logic                                            cand_valid,
  input  logic                                            cand_ready,
  output logic [31:0]                                     cand_window_id,
  output logic [COUNT_WIDTH-1:0]                          cand_count,
  output logic                                            busy,
  output logic                                            done,
  output logic [31:0]                                     best_window_id,
  output logic [COUNT_WIDTH-1:0]                          best_count,
  output logic [31:0]                                     num_candidates
);

  // One extra bit so the limit and candidate count can reach MAX_WINDOWS_IN_REFERENCE.
  localparam int unsigned LimW = LOG2_MAX_WINDOWS + 1;
  localparam logic [LimW-1:0] LimMax = LimW'(MAX_WINDOWS_IN_REFERENCE);

  sel_state_t                  state_q, state_d;
  logic [LOG2_MAX_WINDOWS-1:0] idx_q, idx_d;
  logic [LimW-1:0]             lim_q, lim_d;
  logic [COUNT_WIDTH-1:0]      thr_q, thr_d;
  logic                        cand_valid_q, cand_valid_d;
  logic [LOG2_MAX_WINDOWS-1:0] cand_id_q, cand_id_d;
  logic [COUNT_WIDTH-1:0]      cand_count_q, cand_count_d;
  logic [LOG2_MAX_WINDOWS-1:0] best_id_q, best_id_d;
  logic [COUNT_WIDTH-1:0]      best_count_q, best_count_d;
  logic [LimW-1:0]             num_cand_q, num_cand_d;

  logic [MAX_WINDOWS_IN_REFERENCE-1:0][COUNT_WIDTH-1:0] count_arr;
  logic [COUNT_WIDTH-1:0] cur_count;
  logic [LimW-1:0]        start_lim;
  logic                   advance;
  logic                   hit;
  logic                   is_last;

  assign count_arr = count_bus;
  assign cur_count = count_arr[idx_q];
  assign start_lim = (num_windows > 32'(MAX_WINDOWS_IN_REFERENCE)) ? LimMax :
                     num_windows[LimW-1:0];
  // The output register is free when empty or being drained this cycle.
  assign advance   = !cand_valid_q || cand_ready;
  assign hit       = cur_count >= thr_q;
  assign is_last   = (LimW'(idx_q) + 1'b1) == lim_q;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    lim_d        = lim_q;
    thr_d        = thr_q;
    cand_valid_d = cand_valid_q;
    cand_id_d    = cand_id_q;
    cand_count_d = cand_count_q;
    best_id_d    = best_id_q;
    best_count_d = best_count_q;
    num_cand_d   = num_cand_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          thr_d        = threshold;
          lim_d        = start_lim;
          idx_d        = '0;
          best_id_d    = '0;
          best_count_d = '0;
          num_cand_d   = '0;
          state_d      = (start_lim == '0) ? DRAIN : SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (hit) begin
            cand_valid_d = 1'b1;
            cand_id_d    = idx_q;
            cand_count_d = cur_count;
            num_cand_d   = num_cand_q + 1'b1;
          end else begin
            cand_valid_d = 1'b0;
          end
          // Strict compare keeps the lowest window id on ties.
          if (cur_count > best_count_q) begin
            best_id_d    = idx_q;
            best_count_d = cur_count;
          end
          if (is_last) begin
            state_d = DRAIN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (advance) begin
          cand_valid_d = 1'b0;
          state_d      = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_candidate_selector_n) begin
    if (!reset_candidate_selector_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      lim_q        <= '0;
      thr_q        <= '0;
      cand_valid_q <= 1'b0;
      cand_id_q    <= '0;
      cand_count_q <= '0;
      best_id_q    <= '0;
      best_count_q <= '0;
      num_cand_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      lim_q        <= lim_d;
      thr_q        <= thr_d;
      cand_valid_q <= cand_valid_d;
      cand_id_q    <= cand_id_d;
      cand_count_q <= cand_count_d;
      best_id_q    <= best_id_d;
      best_count_q <= best_count_d;
      num_cand_q   <= num_cand_d;
    end
  end

  assign cand_valid     = cand_valid_q;
  assign cand_window_id = 32'(cand_id_q);
  assign cand_count     = cand_count_q;
  assign busy           = (state_q == SCAN) || (state_q == DRAIN);
  assign done           = (state_q == DONE);
  assign best_window_id = 32'(best_id_q);
  assign best_count     = best_count_q;
  assign num_candidates = 32'(num_cand_q);

endmodule

// File: tb/tb_candidate_selector.sv
// Directed bench for candidate_selector: hand-computed candidate streams, latencies and results.
module tb_candidate_selector;
  import lsh_pkg::*;

  logic                                            clk;
  logic                                            rst_n;
  logic                                            start;
  logic [31:0]                                     num_windows;
  logic [COUNT_WIDTH-1:0]                          threshold;
  logic [COUNT_WIDTH*MAX_WINDOWS_IN_REFERENCE-1:0] count_bus;
  logic                                            cand_valid;
  logic                                            cand_ready;
  logic [31:0]                                     cand_window_id;
  logic [COUNT_WIDTH-1:0]                          cand_count;
  logic                                            busy;
  logic                                            done;
  logic [31:0]                                     best_window_id;
  logic [COUNT_WIDTH-1:0]                          best_count;
  logic [31:0]                                     num_candidates;

  int checks   = 0;
  int failures = 0;
  int q_id[$];
  int q_cnt[$];

  candidate_selector u_dut (
    .clk                        (clk),
    .reset_candidate_selector_n (rst_n),
    .start                      (start),
    .num_windows                (num_windows),
    .threshold                  (threshold),
    .count_bus                  (count_bus),
    .cand_valid                 (cand_valid),
    .cand_ready                 (cand_ready),
    .cand_window_id             (cand_window_id),
    .cand_count                 (cand_count),
    .busy                       (busy),
    .done                       (done),
    .best_window_id             (best_window_id),
    .best_count                 (best_count),
    .num_candidates             (num_candidates)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_count(input int i, input logic [31:0] v);
    count_bus[i*COUNT_WIDTH +: COUNT_WIDTH] = v;
  endtask

  // Pulses start, then steps one negedge at a time: drives cand_ready for the coming edge,
  // logs accepted candidates, and measures the cycle offset at which done is first seen.
  task automatic run_scan(input int n, input logic [31:0] thr, input int stall_id,
                          input int stall_n, input int restart_at, input int abort_at,
                          output int lat, output int held, output logic busy1,
                          output int done_len, output logic busy_at_done);
    int stalls;
    stalls = 0; held = 0; lat = 0; busy1 = 1'b0; done_len = 0; busy_at_done = 1'b1;
    q_id.delete();
    q_cnt.delete();
    @(negedge clk);
    start = 1'b1; num_windows = n; threshold = thr;
    for (int t = 1; t <= n + 50; t++) begin
      @(negedge clk);
      start = (t == restart_at);
      if (t == restart_at) begin
        num_windows = 1;
        threshold   = '0;
      end
      if (t == 1) busy1 = busy;
      if (t == abort_at) begin
        rst_n = 1'b0;
        lat   = t;
        return;
      end
      if (done) begin
        if (lat == 0) begin
          lat          = t;
          busy_at_done = busy;
        end
        done_len++;
      end
      if (lat != 0 && !done) break;
      cand_ready = !(cand_valid && cand_window_id == stall_id && stalls < stall_n);
      if (!cand_ready) stalls++;
      if (cand_valid && cand_window_id == stall_id) held++;
      if (cand_valid && cand_ready) begin
        q_id.push_back(int'(cand_window_id));
        q_cnt.push_back(int'(cand_count));
      end
    end
    cand_ready = 1'b1;
  endtask

  initial begin
    int   lat, held, done_len, bad;
    logic busy1, busy_at_done;

    rst_n = 1'b0; start = 1'b0; num_windows = '0; threshold = '0;
    count_bus = '0; cand_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cand_valid", 32'(cand_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_best_id", best_window_id, 0);
    check("rst_best_count", best_count, 0);
    check("rst_num_cand", num_candidates, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic scan: counts {3,0,5,5}, threshold 3.
    set_count(0, 3); set_count(1, 0); set_count(2, 5); set_count(3, 5);
    run_scan(4, 3, -1, 0, 0, 0, lat, held, busy1, done_len, busy_at_done);
    check("a_num_xfers", q_id.size(), 3);
    check("a_id0", q_id[0], 0);  check("a_cnt0", q_cnt[0], 3);
    check("a_id1", q_id[1], 2);  check("a_cnt1", q_cnt[1], 5);
    check("a_id2", q_id[2], 3);  check("a_cnt2", q_cnt[2], 5);
    check("a_best_id", best_window_id, 2);
    check("a_best_count", best_count, 5);
    check("a_num_cand", num_candidates, 3);
    check("a_done_latency", lat, 6);
    check("a_done_len", done_len, 1);
    check("a_busy_after_start", 32'(busy1), 1);
    check("a_busy_at_done", 32'(busy_at_done), 0);
    check("a_valid_after_done", 32'(cand_valid), 0);

    // Same stimulus, (2,5) back-pressured for 3 cycles.
    run_scan(4, 3, 2, 3, 0, 0, lat, held, busy1, done_len, busy_at_done);
    check("b_num_xfers", q_id.size(), 3);
    check("b_id1", q_id[1], 2);  check("b_cnt1", q_cnt[1], 5);
    check("b_id2", q_id[2], 3);
    check("b_hold_cycles", held, 4);
    check("b_done_latency", lat, 9);
    check("b_num_cand", num_candidates, 3);

    // Empty scan clears the previous results.
    run_scan(0, 3, -1, 0, 0, 0, lat, held, busy1, done_len, busy_at_done);
    check("c_num_xfers", q_id.size(), 0);
    check("c_done_latency", lat, 2);
    check("c_best_id", best_window_id, 0);
    check("c_best_count", best_count, 0);
    check("c_num_cand", num_candidates, 0);

    // Oversized num_windows clamps to the bus size.
    for (int i = 0; i < int'(MAX_WINDOWS_IN_REFERENCE); i++) set_count(i, 1);
    run_scan(2000, 1, -1, 0, 0, 0, lat, held, busy1, done_len, busy_at_done);
    bad = 0;
    foreach (q_id[i]) if (q_id[i] != i || q_cnt[i] != 1) bad++;
    check("d_num_xfers", q_id.size(), 1024);
    check("d_bad_entries", bad, 0);
    check("d_best_id", best_window_id, 0);
    check("d_best_count", best_count, 1);
    check("d_num_cand", num_candidates, 1024);
    check("d_done_latency", lat, 1026);

    // start mid-scan is ignored.
    set_count(0, 3); set_count(1, 0); set_count(2, 5); set_count(3, 5);
    run_scan(4, 3, -1, 0, 3, 0, lat, held, busy1, done_len, busy_at_done);
    check("e_num_xfers", q_id.size(), 3);
    check("e_id2", q_id[2], 3);
    check("e_done_latency", lat, 6);
    check("e_num_cand", num_candidates, 3);
    check("e_best_id", best_window_id, 2);

    // Reset asserted while the scan index is 10.
    for (int i = 0; i < 4; i++) set_count(i, 1);
    run_scan(20, 1, -1, 0, 0, 11, lat, held, busy1, done_len, busy_at_done);
    #1;
    check("f_rst_cand_valid", 32'(cand_valid), 0);
    check("f_rst_busy", 32'(busy), 0);
    check("f_rst_num_cand", num_candidates, 0);
    check("f_rst_best_count", best_count, 0);
    check("f_rst_cand_id", cand_window_id, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cand_ready = 1'b1;
    @(negedge clk);

    // Threshold 0 with a tie: counts {0,2,2}.
    set_count(0, 0); set_count(1, 2); set_count(2, 2);
    run_scan(3, 0, -1, 0, 0, 0, lat, held, busy1, done_len, busy_at_done);
    check("g_num_xfers", q_id.size(), 3);
    check("g_id0", q_id[0], 0);  check("g_cnt0", q_cnt[0], 0);
    check("g_id2", q_id[2], 2);  check("g_cnt2", q_cnt[2], 2);
    check("g_best_id", best_window_id, 1);
    check("g_best_count", best_count, 2);
    check("g_num_cand", num_candidates, 3);
    check("g_done_latency", lat, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
